// File: rtl/cpu_defs.sv
// Shared execute-stage definitions: ALU op codes, divider step count and
// the HI/LO divide FSM state encoding.
package cpu_defs;

    localparam logic [7:0] ALU_MFHI  = 8'h10;
    localparam logic [7:0] ALU_MTHI  = 8'h11;
    localparam logic [7:0] ALU_MFLO  = 8'h12;
    localparam logic [7:0] ALU_MTLO  = 8'h13;
    localparam logic [7:0] ALU_MULT  = 8'h18;
    localparam logic [7:0] ALU_MULTU = 8'h19;
    localparam logic [7:0] ALU_DIV   = 8'h1A;
    localparam logic [7:0] ALU_DIVU  = 8'h1B;

    localparam int unsigned DIV_STEPS = 32;
    localparam int unsigned CNT_W     = $clog2(DIV_STEPS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } divState_t;

    function automatic logic isDivOp(input logic [7:0] op);
        return (op == ALU_DIV) || (op == ALU_DIVU);
    endfunction

endpackage

// File: rtl/div_iter_u.sv
// Unsigned restoring divider: one quotient bit per cycle over DIV_STEPS
// cycles, with start/abort control and busy/done status.
module div_iter_u
    import cpu_defs::*;
#(
    parameter int unsigned W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [W-1:0]     dividend,
    input  logic [W-1:0]     divisor,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] count,
    output logic [W-1:0]     quotient,
    output logic [W-1:0]     remainder
);

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DIV_STEPS - 1);

    logic [W-1:0] divReg;
    logic [W:0]   trial;
    logic [W:0]   diff;
    logic         fits;
    logic [W-1:0] stepRem;
    logic [W-1:0] stepQuo;

    // Shift in the next dividend bit and subtract if the divisor fits.
    always_comb begin
        trial   = {remainder, quotient[W-1]};
        diff    = trial - {1'b0, divReg};
        fits    = ~diff[W];
        stepRem = fits ? diff[W-1:0] : trial[W-1:0];
        stepQuo = {quotient[W-2:0], fits};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            count     <= '0;
            quotient  <= '0;
            remainder <= '0;
            divReg    <= '0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                busy <= 1'b0;
            end else if (start) begin
                busy      <= 1'b1;
                count     <= '0;
                quotient  <= dividend;
                remainder <= '0;
                divReg    <= divisor;
            end else if (busy) begin
                quotient  <= stepQuo;
                remainder <= stepRem;
                count     <= count + CNT_W'(1);
                if (count == LAST_STEP) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/exe_hilo_md.sv
// Execute-stage multiply/divide unit owning the HI/LO pair; single-cycle
// multiply and moves, iterative divide with a pipeline stall.
module exe_hilo_md
    import cpu_defs::*;
#(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         validE,
    input  logic [7:0]   ALUControlE,
    input  logic         hilowriteE,
    input  logic [W-1:0] srcaE,
    input  logic [W-1:0] srcbE,
    input  logic         flushE,
    output logic         stallE,
    output logic [W-1:0] hiloresultE,
    output logic [W-1:0] hiE,
    output logic [W-1:0] loE
);

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DIV_STEPS - 1);

    divState_t        state;
    logic             we;
    logic             signedMul;
    logic             signedDiv;
    logic [2*W-1:0]   aExt;
    logic [2*W-1:0]   bExt;
    logic [2*W-1:0]   product;
    logic             negA;
    logic             negB;
    logic [W-1:0]     magA;
    logic [W-1:0]     magB;
    logic             startDiv;
    logic             abortDiv;
    logic             negQ;
    logic             negR;
    logic             divZero;
    logic [W-1:0]     dividendRaw;
    logic [W-1:0]     fixQ;
    logic [W-1:0]     fixR;
    logic             divBusy;
    logic             divDone;
    logic [CNT_W-1:0] divCount;
    logic [W-1:0]     divQuo;
    logic [W-1:0]     divRem;

    // One multiplier serves both signednesses via sign/zero extension to 2W.
    always_comb begin
        we        = validE & hilowriteE & ~flushE;
        signedMul = (ALUControlE == ALU_MULT);
        aExt      = {{W{signedMul & srcaE[W-1]}}, srcaE};
        bExt      = {{W{signedMul & srcbE[W-1]}}, srcbE};
        product   = aExt * bExt;

        signedDiv = (ALUControlE == ALU_DIV);
        negA      = signedDiv & srcaE[W-1];
        negB      = signedDiv & srcbE[W-1];
        magA      = negA ? -srcaE : srcaE;
        magB      = negB ? -srcbE : srcbE;

        startDiv  = (state == IDLE) & we & isDivOp(ALUControlE);
        abortDiv  = (state == BUSY) & flushE;
        stallE    = startDiv | (state == BUSY);

        fixQ = divZero ? {W{1'b1}} : (negQ ? -divQuo : divQuo);
        fixR = divZero ? dividendRaw : (negR ? -divRem : divRem);

        hiloresultE = '0;
        if (ALUControlE == ALU_MFHI) begin
            hiloresultE = hiE;
        end else if (ALUControlE == ALU_MFLO) begin
            hiloresultE = loE;
        end
    end

    div_iter_u #(.W(W)) uDiv (
        .clk       (clk),
        .reset     (reset),
        .start     (startDiv),
        .abort     (abortDiv),
        .dividend  (magA),
        .divisor   (magB),
        .busy      (divBusy),
        .done      (divDone),
        .count     (divCount),
        .quotient  (divQuo),
        .remainder (divRem)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            hiE         <= '0;
            loE         <= '0;
            negQ        <= 1'b0;
            negR        <= 1'b0;
            divZero     <= 1'b0;
            dividendRaw <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (we) begin
                        case (ALUControlE)
                            ALU_MULT, ALU_MULTU: begin
                                hiE <= product[2*W-1:W];
                                loE <= product[W-1:0];
                            end
                            ALU_MTHI: hiE <= srcaE;
                            ALU_MTLO: loE <= srcaE;
                            ALU_DIV, ALU_DIVU: begin
                                state       <= BUSY;
                                negQ        <= negA ^ negB;
                                negR        <= negA;
                                divZero     <= (srcbE == '0);
                                dividendRaw <= srcaE;
                            end
                            default: ;
                        endcase
                    end
                end
                BUSY: begin
                    if (flushE) begin
                        state <= IDLE;
                    end else if (divBusy && divCount == LAST_STEP) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    // The divide is still in E here; it leaves on this edge.
                    state <= IDLE;
                    if (!flushE && divDone) begin
                        hiE <= fixR;
                        loE <= fixQ;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
